// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART timing defaults, arbiter FSM state encoding and small helpers.
package uart_tx_arbiter_pkg;

    localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
    localparam int unsigned BAUD_DEF       = 9600;
    localparam int unsigned FRAME_BITS_DEF = 10;
    localparam int unsigned GUARD_DEF      = 2;
    localparam int unsigned N_REQ_DEF      = 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t TRIG = 2'd1;
    localparam state_t WAIT = 2'd2;

    function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                               input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]            valid,
    input  logic [idx_width(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]            grant_c,
    output logic [idx_width(N_REQ)-1:0] idx_c,
    output logic                        found_c
);

    localparam int unsigned GW = idx_width(N_REQ);

    // Two passes: indices >= ptr first, then the wrapped indices below ptr.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found_c = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_c && valid[i] && (GW'(i) >= ptr)) begin
                found_c    = 1'b1;
                grant_c[i] = 1'b1;
                idx_c      = GW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_c && valid[i] && (GW'(i) < ptr)) begin
                found_c    = 1'b1;
                grant_c[i] = 1'b1;
                idx_c      = GW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte sources, with frame pacing
// (one tx_trig per byte followed by a fixed hold-off since uart_tx reports no busy).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BAUD       = BAUD_DEF,
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned GUARD      = GUARD_DEF
) (
    input  logic                        sclk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [8*N_REQ-1:0]          req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_trig,
    output logic                        tx_busy,
    output logic [idx_width(N_REQ)-1:0] grant_id
);

    localparam int unsigned GW           = idx_width(N_REQ);
    localparam int unsigned FRAME_CYCLES = bit_cycles(CLK_FREQ, BAUD) * FRAME_BITS + GUARD;
    localparam int unsigned CW           = $clog2(FRAME_CYCLES + 1);

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   ptr_nxt_c;
    logic [GW-1:0]   gidx_c;
    logic [N_REQ-1:0] grant_c;
    logic            found_c;
    logic            accept_c;
    logic [CW-1:0]   cnt;
    logic [7:0]      sel_data_c;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid   (req_valid),
        .ptr     (ptr),
        .grant_c (grant_c),
        .idx_c   (gidx_c),
        .found_c (found_c)
    );

    // Byte of the granted requester.
    always_comb begin
        sel_data_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                sel_data_c = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        ptr_nxt_c = (gidx_c == GW'(N_REQ - 1)) ? '0 : gidx_c + GW'(1);
    end

    // State register.
    always_ff @(posedge sclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = TRIG;
            TRIG:    state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; ready is withheld during reset so nothing is accepted.
    always_comb begin
        req_ready = '0;
        accept_c  = 1'b0;
        if ((state == IDLE) && !reset) begin
            req_ready = grant_c;
            accept_c  = found_c;
        end
    end

    // Registered datapath: captured byte, grant, pointer, trigger and hold-off counter.
    always_ff @(posedge sclk) begin
        if (reset) begin
            tx_data  <= '0;
            tx_trig  <= 1'b0;
            tx_busy  <= 1'b0;
            grant_id <= '0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            tx_trig <= accept_c;
            if (accept_c) begin
                tx_data  <= sel_data_c;
                grant_id <= gidx_c;
                ptr      <= ptr_nxt_c;
                tx_busy  <= 1'b1;
            end
            if (state == TRIG) begin
                cnt <= CW'(FRAME_CYCLES - 1);
            end else if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    tx_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table, hand-written corner sequences and
// random traffic, all checked every cycle against a frame-timing reference model.
module tb_uart_tx_arbiter;

    localparam int N          = 2;
    localparam int CLK_FREQ   = 1000;
    localparam int BAUD       = 100;
    localparam int FRAME_BITS = 10;
    localparam int GUARD      = 2;
    localparam int FRAME      = (CLK_FREQ / BAUD) * FRAME_BITS + GUARD;

    logic        sclk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_trig;
    logic        tx_busy;
    logic [0:0]  grant_id;

    uart_tx_arbiter #(
        .N_REQ(N), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FRAME_BITS(FRAME_BITS), .GUARD(GUARD)
    ) dut (
        .sclk      (sclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_trig   (tx_trig),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: line is free again at cycle m_free; outputs expected this cycle.
    int         m_ptr;
    logic       m_trig;
    logic       m_busy;
    logic [7:0] m_data;
    int         m_gid;
    int         m_free;

    logic [1:0] obs_ready;
    logic       obs_trig;
    logic       obs_busy;
    logic [7:0] obs_data;
    logic       obs_gid;

    int         trig_cyc_q[$];
    logic [7:0] trig_dat_q[$];

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [15:0] d;
        int          n;
        logic [1:0]  ready;
        logic        trig;
        logic        busy;
        logic [7:0]  data;
        logic        gid;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] pick(input logic [1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return 2'(1 << j);
        end
        return 2'b00;
    endfunction

    // One clock cycle: drive inputs, check everything against the model, advance the model.
    task automatic step(input logic rst, input logic [1:0] v, input logic [15:0] d);
        logic [1:0] er;
        int g;
        @(negedge sclk);
        reset     = rst;
        req_valid = v;
        req_data  = d;
        #1;
        er = (rst || cyc < m_free) ? 2'b00 : pick(v, m_ptr);
        obs_ready = req_ready;
        obs_trig  = tx_trig;
        obs_busy  = tx_busy;
        obs_data  = tx_data;
        obs_gid   = grant_id;
        chk("ready", 32'(req_ready), 32'(er));
        chk("trig",  32'(tx_trig),   32'(m_trig));
        chk("busy",  32'(tx_busy),   32'(m_busy));
        chk("data",  32'(tx_data),   32'(m_data));
        chk("gid",   32'(grant_id),  32'(m_gid));
        if (tx_trig === 1'b1) begin
            trig_cyc_q.push_back(cyc);
            trig_dat_q.push_back(tx_data);
        end
        if (rst) begin
            m_ptr = 0; m_trig = 1'b0; m_busy = 1'b0; m_data = 8'h00; m_gid = 0;
            m_free = cyc + 1;
        end else if (er != 2'b00) begin
            g      = er[1] ? 1 : 0;
            m_data = d[8*g +: 8];
            m_gid  = g;
            m_ptr  = (g + 1) % N;
            m_trig = 1'b1;
            m_busy = 1'b1;
            m_free = cyc + FRAME + 2;
        end else begin
            m_trig = 1'b0;
            m_busy = (cyc + 1 < m_free);
        end
        cyc++;
    endtask

    initial begin
        int t_last;
        int t_rst;
        int n_trig;
        int busy_seen;
        int ready_seen;

        tbl[0]  = '{1'b1, 2'b11, 16'h2211, 2,   2'b00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 2'b01, 16'h00A5, 1,   2'b01, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, 16'h0000, 1,   2'b00, 1'b1, 1'b1, 8'hA5, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 16'h0000, 101, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 16'h0000, 1,   2'b00, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 16'h0000, 1,   2'b00, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[6]  = '{1'b0, 2'b10, 16'h5A00, 1,   2'b10, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 16'h0000, 103, 2'b00, 1'b1, 1'b1, 8'h5A, 1'b1};
        tbl[8]  = '{1'b0, 2'b11, 16'h8877, 1,   2'b01, 1'b0, 1'b0, 8'h5A, 1'b1};
        tbl[9]  = '{1'b0, 2'b00, 16'h0000, 103, 2'b00, 1'b1, 1'b1, 8'h77, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 16'h0000, 1,   2'b00, 1'b0, 1'b0, 8'h77, 1'b0};

        reset = 1'b1; req_valid = 2'b00; req_data = 16'h0000;
        repeat (2) @(posedge sclk);
        m_ptr = 0; m_trig = 1'b0; m_busy = 1'b0; m_data = 8'h00; m_gid = 0; m_free = 0;

        // Directed table: reset with valid, single byte, pointer wrap.
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].rst, tbl[i].v, tbl[i].d);
                if (k == 0) begin
                    chk($sformatf("t%0d_ready", i), 32'(obs_ready), 32'(tbl[i].ready));
                    chk($sformatf("t%0d_trig", i),  32'(obs_trig),  32'(tbl[i].trig));
                    chk($sformatf("t%0d_busy", i),  32'(obs_busy),  32'(tbl[i].busy));
                    chk($sformatf("t%0d_data", i),  32'(obs_data),  32'(tbl[i].data));
                    chk($sformatf("t%0d_gid", i),   32'(obs_gid),   32'(tbl[i].gid));
                end
            end
        end

        // Contention: both valid held, expect strict alternation at fixed spacing.
        step(1'b1, 2'b00, 16'h0000);
        trig_cyc_q.delete(); trig_dat_q.delete();
        for (int k = 0; k < 600 && trig_cyc_q.size() < 4; k++) step(1'b0, 2'b11, 16'h2211);
        chk("contention_count", 32'(trig_cyc_q.size()), 32'd4);
        for (int i = 0; i < trig_cyc_q.size(); i++) begin
            chk($sformatf("contention_data%0d", i), 32'(trig_dat_q[i]), (i % 2 == 1) ? 32'h22 : 32'h11);
            if (i > 0) chk($sformatf("contention_gap%0d", i),
                           32'(trig_cyc_q[i] - trig_cyc_q[i-1]), 32'(FRAME + 2));
        end
        t_last = (trig_cyc_q.size() > 0) ? trig_cyc_q[trig_cyc_q.size()-1] : cyc;

        // Busy: a pulse during the hold-off is ignored, a held request wins the first idle cycle.
        step(1'b0, 2'b00, 16'h0000);
        step(1'b0, 2'b10, 16'h9900);
        chk("busy_pulse_ready", 32'(obs_ready), 32'd0);
        repeat (5) step(1'b0, 2'b00, 16'h0000);
        trig_cyc_q.delete(); trig_dat_q.delete();
        for (int k = 0; k < 300 && trig_cyc_q.size() < 1; k++) step(1'b0, 2'b10, 16'h4400);
        chk("busy_trig_seen", 32'(trig_cyc_q.size()), 32'd1);
        if (trig_cyc_q.size() > 0) begin
            chk("busy_gap", 32'(trig_cyc_q[0] - t_last), 32'(FRAME + 2));
            chk("busy_data", 32'(trig_dat_q[0]), 32'h44);
            t_last = trig_cyc_q[0];
        end

        // Reset in WAIT when the hold-off counter reads 50.
        while (cyc < t_last + 52) step(1'b0, 2'b00, 16'h0000);
        t_rst = cyc;
        step(1'b1, 2'b00, 16'h0000);
        step(1'b0, 2'b00, 16'h0000);
        chk("rst_trig", 32'(obs_trig), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_data", 32'(obs_data), 32'd0);
        chk("rst_gid",  32'(obs_gid),  32'd0);
        chk("rst_cycle", 32'(cyc - t_rst), 32'd2);
        step(1'b0, 2'b11, 16'h003C);
        chk("after_rst_ready", 32'(obs_ready), 32'b01);
        step(1'b0, 2'b00, 16'h0000);
        chk("after_rst_trig", 32'(obs_trig), 32'd1);
        chk("after_rst_data", 32'(obs_data), 32'h3C);

        // Idle: no requests, nothing moves.
        repeat (FRAME + 5) step(1'b0, 2'b00, 16'h0000);
        trig_cyc_q.delete(); trig_dat_q.delete();
        busy_seen = 0; ready_seen = 0;
        repeat (500) begin
            step(1'b0, 2'b00, 16'h0000);
            if (obs_busy !== 1'b0) busy_seen++;
            if (obs_ready !== 2'b00) ready_seen++;
        end
        n_trig = trig_cyc_q.size();
        chk("idle_trig", 32'(n_trig), 32'd0);
        chk("idle_busy", 32'(busy_seen), 32'd0);
        chk("idle_ready", 32'(ready_seen), 32'd0);

        // Random traffic with occasional resets.
        repeat (3000) begin
            step(($urandom % 150) == 0, 2'($urandom % 4), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
